// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared types and constants for the shifter datapath
package shifter_pkg;

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

   localparam logic BIT_ORDER_MSB = 1'b0;
   localparam logic BIT_ORDER_LSB = 1'b1;

endpackage

// File: rtl/deser_out_reg.sv
// rtl/deser_out_reg.sv - one-entry valid/ready holding register with overrun pulse
module deser_out_reg
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             outReady,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   output logic             overrun
);

   out_state_t       state, state_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             ovr_nxt;

   always_comb begin
      state_nxt = state;
      data_nxt  = outData;
      ovr_nxt   = 1'b0;
      case (state)
         OUT_EMPTY: begin
            if (load) begin
               state_nxt = OUT_FULL;
               data_nxt  = word;
            end
         end
         OUT_FULL: begin
            // A completion in the handshake cycle refills the slot; without the handshake it is dropped.
            if (load && outReady) begin
               data_nxt = word;
            end else if (load) begin
               ovr_nxt = 1'b1;
            end else if (outReady) begin
               state_nxt = OUT_EMPTY;
            end
         end
         default: state_nxt = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= OUT_EMPTY;
         outData  <= '0;
         outValid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         outData  <= data_nxt;
         outValid <= (state_nxt == OUT_FULL);
         overrun  <= ovr_nxt;
      end
   end

endmodule

// File: rtl/byte_deserializer.sv
// rtl/byte_deserializer.sv - serial-to-parallel receiver with per-word bit order
module byte_deserializer
   import shifter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bitIn,
   input  logic             bitValid,
   input  logic             lsbFirst,
   input  logic             frameClr,
   output logic [WIDTH-1:0] outData,
   output logic             outValid,
   input  logic             outReady,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] sh, sh_nxt, sh_shift;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             ordL, ordL_nxt, ord_eff;
   logic             accept, complete;

   always_comb begin
      // The order input only matters on the first bit of a word.
      ord_eff  = (cnt == '0) ? lsbFirst : ordL;
      sh_shift = (ord_eff == BIT_ORDER_LSB) ? {bitIn, sh[WIDTH-1:1]}
                                            : {sh[WIDTH-2:0], bitIn};
      accept   = bitValid && !frameClr;
      complete = accept && (cnt == CW'(WIDTH - 1));

      sh_nxt   = sh;
      cnt_nxt  = cnt;
      ordL_nxt = ordL;
      if (frameClr) begin
         sh_nxt  = '0;
         cnt_nxt = '0;
      end else if (accept) begin
         sh_nxt   = sh_shift;
         ordL_nxt = ord_eff;
         cnt_nxt  = complete ? '0 : cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh   <= '0;
         cnt  <= '0;
         ordL <= BIT_ORDER_MSB;
      end else begin
         sh   <= sh_nxt;
         cnt  <= cnt_nxt;
         ordL <= ordL_nxt;
      end
   end

   assign busy = (cnt != '0);

   deser_out_reg #(.WIDTH(WIDTH)) u_out_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (complete),
      .word     (sh_shift),
      .outReady (outReady),
      .outData  (outData),
      .outValid (outValid),
      .overrun  (overrun)
   );

endmodule

// File: tb/tb_byte_deserializer.sv
// tb/tb_byte_deserializer.sv - scoreboard bench for byte_deserializer
module tb_byte_deserializer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bitIn = 1'b0;
   logic       bitValid = 1'b0;
   logic       lsbFirst = 1'b0;
   logic       frameClr = 1'b0;
   logic       outReady = 1'b0;
   logic [7:0] outData;
   logic       outValid;
   logic       overrun;
   logic       busy;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   byte_deserializer #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bitIn    (bitIn),
      .bitValid (bitValid),
      .lsbFirst (lsbFirst),
      .frameClr (frameClr),
      .outData  (outData),
      .outValid (outValid),
      .outReady (outReady),
      .overrun  (overrun),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake pops the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && outValid && outReady) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none at %0t", outData, $time);
         end else begin
            chk("word", {24'h0, outData}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic lsb);
      bitValid = 1'b1;
      bitIn    = b;
      lsbFirst = lsb;
      step(1);
      bitValid = 1'b0;
   endtask

   task automatic send_msb(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b1011_0010;

      step(2);
      chk("rst_outValid", {31'h0, outValid}, 32'h0);
      chk("rst_outData", {24'h0, outData}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      rst_n = 1'b1;
      step(1);
      chk("idle_overrun", {31'h0, overrun}, 32'h0);

      // MSB-first B2
      outReady = 1'b1;
      exp_q.push_back(8'hB2);
      for (int i = 0; i < 7; i++) send_bit(pat[7-i], 1'b0);
      chk("busy_7bits", {31'h0, busy}, 32'h1);
      chk("valid_before_last", {31'h0, outValid}, 32'h0);
      send_bit(pat[0], 1'b0);
      chk("busy_wrap", {31'h0, busy}, 32'h0);
      chk("msb_valid", {31'h0, outValid}, 32'h1);
      chk("msb_data", {24'h0, outData}, 32'hB2);
      step(1);
      chk("msb_valid_one_cycle", {31'h0, outValid}, 32'h0);

      // LSB-first with lsbFirst toggling mid-word -> 4D
      exp_q.push_back(8'h4D);
      for (int i = 0; i < 8; i++) send_bit(pat[7-i], (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("lsb_data", {24'h0, outData}, 32'h4D);
      step(1);

      // Overrun: A5 held, 3C dropped
      outReady = 1'b0;
      exp_q.push_back(8'hA5);
      send_msb(8'hA5);
      send_msb(8'h3C);
      chk("ovr_pulse", {31'h0, overrun}, 32'h1);
      chk("ovr_data_held", {24'h0, outData}, 32'hA5);
      chk("ovr_valid", {31'h0, outValid}, 32'h1);
      step(1);
      chk("ovr_pulse_end", {31'h0, overrun}, 32'h0);
      chk("ovr_still_valid", {31'h0, outValid}, 32'h1);
      outReady = 1'b1;
      step(1);
      chk("ovr_drained", {31'h0, outValid}, 32'h0);

      // Handshake coincident with completion
      outReady = 1'b0;
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_msb(8'h11);
      for (int i = 7; i >= 1; i--) send_bit(pat[0] ^ 1'b0 ^ (8'h22 >> i), 1'b0);
      outReady = 1'b1;
      send_bit(1'b0, 1'b0);
      chk("coin_valid", {31'h0, outValid}, 32'h1);
      chk("coin_data", {24'h0, outData}, 32'h22);
      chk("coin_no_ovr", {31'h0, overrun}, 32'h0);
      step(1);
      chk("coin_drained", {31'h0, outValid}, 32'h0);

      // frameClr beats bitValid, then F0 with stall gaps
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("pre_clr_busy", {31'h0, busy}, 32'h1);
      frameClr = 1'b1;
      send_bit(1'b1, 1'b0);
      frameClr = 1'b0;
      chk("clr_busy", {31'h0, busy}, 32'h0);
      exp_q.push_back(8'hF0);
      for (int i = 7; i >= 0; i--) begin
         send_bit(i >= 4, 1'b0);
         if (i == 5) step(3);
      end
      chk("clr_data", {24'h0, outData}, 32'hF0);
      step(1);

      // Async reset mid-word with a word held
      outReady = 1'b0;
      send_msb(8'h77);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      chk("pre_rst_valid", {31'h0, outValid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'h0, outValid}, 32'h0);
      chk("arst_data", {24'h0, outData}, 32'h0);
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_ovr", {31'h0, overrun}, 32'h0);
      step(1);
      rst_n = 1'b1;
      outReady = 1'b1;
      step(1);
      exp_q.push_back(8'h81);
      send_msb(8'h81);
      chk("post_rst_data", {24'h0, outData}, 32'h81);

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) step(1);
      chk("queue_drained", exp_q.size(), 32'h0);
      step(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
